bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/bram_arbiter_if.sv | 41 ++++
 rtl/bram_arb_rr.sv | 39 +++
 rtl/bram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
//   state_e   : transaction FSM states of bram_arbiter
//   RESP_*    : AXI4-Lite response encodings
//   DATA_W/STRB_W : fixed data-path widths
package bram_arb_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_e;

endpackage

// File: rtl/bram_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the BRAM controller (slave).
//   Write address : awaddr, awvalid / awready
//   Write data    : wdata, wstrb, wvalid / wready
//   Write resp    : bresp, bvalid / bready
//   Read address  : araddr, arvalid / arready
//   Read data     : rdata, rresp, rvalid / rready
interface bram_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/bram_arb_rr.sv
// Two-way round-robin picker with a last-granted pointer.
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : active requests
//   grant_en  : a grant is being taken this cycle (pointer may move)
//   gnt_idx   : index of the winner (meaningful only when |req)
module bram_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_idx
);

  // last_q holds the index granted most recently; reset to 1 so requester 0 wins first.
  logic last_q;
  logic last_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_idx = req[1];
    last_d  = last_q;
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end
    if (grant_en && (|req)) begin
      last_d = gnt_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two simple request/ack ports onto a single AXI4-Lite master,
// one transaction outstanding at a time.
//   clk, rst          : clock, synchronous active-high reset
//   rqN_req/we/addr/wdata/wstrb : requester N command, held until rqN_ack
//   rqN_ack           : one-cycle completion pulse
//   rqN_rdata/resp    : result, valid with rqN_ack and held until N's next ack
//   s_axi             : AXI4-Lite master port
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic [STRB_W-1:0] rq0_wstrb,
  output logic              rq0_ack,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic [1:0]        rq0_resp,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic [STRB_W-1:0] rq1_wstrb,
  output logic              rq1_ack,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [1:0]        rq1_resp,
  bram_arbiter_if.master    s_axi
);

  state_e                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic [ADDR_W-1:0]       awaddr_q, awaddr_d;
  logic                    awvalid_q, awvalid_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic [ADDR_W-1:0]       araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0][1:0]         resp_q, resp_d;

  // A req still high while its own ack is showing is the tail of the finished
  // transaction; it becomes a fresh request one cycle later.
  logic [1:0] eff_req;
  logic       gnt_idx;
  logic       g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic       aw_done;
  logic       w_done;

  assign eff_req = {rq1_req & ~ack_q[1], rq0_req & ~ack_q[0]};

  bram_arb_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (eff_req),
    .grant_en (state_q == IDLE),
    .gnt_idx  (gnt_idx)
  );

  assign g_we    = gnt_idx ? rq1_we    : rq0_we;
  assign g_addr  = gnt_idx ? rq1_addr  : rq0_addr;
  assign g_wdata = gnt_idx ? rq1_wdata : rq0_wdata;
  assign g_wstrb = gnt_idx ? rq1_wstrb : rq0_wstrb;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || s_axi.awready;
  assign w_done  = !wvalid_q  || s_axi.wready;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    unique case (state_q)
      IDLE: begin
        if (|eff_req) begin
          sel_d = gnt_idx;
          if (g_we) begin
            awaddr_d  = g_addr;
            wdata_d   = g_wdata;
            wstrb_d   = g_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            araddr_d  = g_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (awvalid_q && s_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && s_axi.wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.bvalid && bready_q) begin
          bready_d      = 1'b0;
          resp_d[sel_q] = s_axi.bresp;
          ack_d[sel_q]  = 1'b1;
          state_d       = IDLE;
        end
      end
      RD_ADDR: begin
        if (s_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.rvalid && rready_q) begin
          rready_d       = 1'b0;
          rdata_d[sel_q] = s_axi.rdata;
          resp_d[sel_q]  = s_axi.rresp;
          ack_d[sel_q]   = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-requester result registers are reset as well, because their reset value is visible on the requester ports.
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= {RESP_OKAY, RESP_OKAY};
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign s_axi.awaddr  = awaddr_q;
  assign s_axi.awvalid = awvalid_q;
  assign s_axi.wdata   = wdata_q;
  assign s_axi.wstrb   = wstrb_q;
  assign s_axi.wvalid  = wvalid_q;
  assign s_axi.bready  = bready_q;
  assign s_axi.araddr  = araddr_q;
  assign s_axi.arvalid = arvalid_q;
  assign s_axi.rready  = rready_q;

  assign rq0_ack   = ack_q[0];
  assign rq1_ack   = ack_q[1];
  assign rq0_rdata = rdata_q[0];
  assign rq1_rdata = rdata_q[1];
  assign rq0_resp  = resp_q[0];
  assign rq1_resp  = resp_q[1];

endmodule
